// File: rtl/shifter_sched.sv
// Round-robin scheduler sharing one combinational shifter between two
// requesters. A count wider than the shifter's own count field is handled by
// running several passes of at most 2^C-1 positions each.

module shifter #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int O = 2
) (
  input  logic [N-1:0] sh_in_i,
  input  logic [C-1:0] sh_cnt_i,
  input  logic [O-1:0] sh_op_i,
  output logic [N-1:0] sh_out_o
);

  logic [31:0] amt;
  logic [31:0] rot_amt;

  // Op decode: 0 rotate left, 1 sll, 2 sra, 3 srl.
  always_comb begin
    amt     = 32'(sh_cnt_i);
    rot_amt = amt % 32'(N);
    case (sh_op_i)
      O'(0):   sh_out_o = (sh_in_i << rot_amt) | (sh_in_i >> (32'(N) - rot_amt));
      O'(1):   sh_out_o = sh_in_i << amt;
      O'(2):   sh_out_o = N'($signed(sh_in_i) >>> amt);
      default: sh_out_o = sh_in_i >> amt;
    endcase
  end

endmodule

module shifter_sched #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int O = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_in,
  input  logic [C:0]   req0_cnt,
  input  logic [O-1:0] req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_in,
  input  logic [C:0]   req1_cnt,
  input  logic [O-1:0] req1_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_id,
  output logic         busy
);

  // state | meaning
  // IDLE  | arbitrating, accepts one request
  // RUN   | one shifter pass per cycle until rem fits in a single pass
  // DONE  | result held until the consumer takes it
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [C:0] MAXP = {1'b0, {C{1'b1}}};

  state_t       state_q, state_d;
  logic         rr_ptr_q, rr_ptr_d;
  logic [N-1:0] work_data_q, work_data_d;
  logic [C:0]   rem_q, rem_d;
  logic [O-1:0] work_op_q, work_op_d;
  logic         work_id_q, work_id_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic         out_id_q, out_id_d;

  logic         grant;
  logic [C-1:0] sh_cnt;
  logic [N-1:0] sh_out;

  // Lone valid wins; under contention the round-robin pointer decides.
  always_comb begin
    grant      = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
    req0_ready = (state_q == IDLE) && req0_valid && !grant;
    req1_ready = (state_q == IDLE) && req1_valid &&  grant;
    sh_cnt     = (rem_q > MAXP) ? MAXP[C-1:0] : rem_q[C-1:0];
  end

  shifter #(.N(N), .C(C), .O(O)) u_shifter (
    .sh_in_i  (work_data_q),
    .sh_cnt_i (sh_cnt),
    .sh_op_i  (work_op_q),
    .sh_out_o (sh_out)
  );

  // Next-state logic: accept, per-pass update, result handoff.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    work_data_d = work_data_q;
    rem_d       = rem_q;
    work_op_d   = work_op_q;
    work_id_d   = work_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          work_data_d = req0_in;
          rem_d       = req0_cnt;
          work_op_d   = req0_op;
          work_id_d   = 1'b0;
          rr_ptr_d    = 1'b1;
          state_d     = RUN;
        end else if (req1_ready) begin
          work_data_d = req1_in;
          rem_d       = req1_cnt;
          work_op_d   = req1_op;
          work_id_d   = 1'b1;
          rr_ptr_d    = 1'b0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (rem_q > MAXP) begin
          work_data_d = sh_out;
          rem_d       = rem_q - MAXP;
        end else begin
          out_data_d  = sh_out;
          out_id_d    = work_id_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      work_data_q <= '0;
      rem_q       <= '0;
      work_op_q   <= '0;
      work_id_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      work_data_q <= work_data_d;
      rem_q       <= rem_d;
      work_op_q   <= work_op_d;
      work_id_q   <= work_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shifter_sched.sv
module tb_shifter_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_in, req1_in;
  logic [4:0]  req0_cnt, req1_cnt;
  logic [1:0]  req0_op, req1_op;
  logic        out_valid, out_ready, out_id, busy;
  logic [15:0] out_data;

  int ncomp = 0;
  int nfail = 0;

  shifter_sched #(.N(16), .C(4), .O(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
    .req0_cnt(req0_cnt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
    .req1_cnt(req1_cnt), .req1_op(req1_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          id;
    logic [15:0] din;
    logic [4:0]  cnt;
    logic [1:0]  op;
    logic [15:0] exp_d;
    int          exp_p;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncomp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request on a single requester, then collect and consume the result.
  task automatic do_req(input bit id, input logic [15:0] d, input logic [4:0] c,
                        input logic [1:0] op, input logic [15:0] exp_d, input int exp_p);
    int cyc;
    if (id) begin req1_valid = 1; req1_in = d; req1_cnt = c; req1_op = op; end
    else    begin req0_valid = 1; req0_in = d; req0_cnt = c; req0_op = op; end
    #1;
    chk("ready", id ? req1_ready : req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    req0_in = ~d; req1_in = ~d; req0_cnt = ~c; req1_cnt = ~c; req0_op = ~op; req1_op = ~op;
    chk("busy_run", busy, 1);
    cyc = 0;
    while (!out_valid && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("out_valid", out_valid, 1);
    chk("latency", cyc, exp_p);
    chk("out_data", out_data, exp_d);
    chk("out_id", out_id, id);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("valid_drop", out_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          grants[8];
    int          ids[8];
    int          ng, no, bad_ready;
    logic [15:0] hold_d;
    logic        hold_id;

    vecs[0] = '{0, 16'h8001,  1, 2'b00, 16'h0003, 1};
    vecs[1] = '{1, 16'h1234, 16, 2'b00, 16'h1234, 2};
    vecs[2] = '{0, 16'h0001, 20, 2'b01, 16'h0000, 2};
    vecs[3] = '{0, 16'h8000, 31, 2'b10, 16'hFFFF, 3};
    vecs[4] = '{1, 16'hF000,  4, 2'b11, 16'h0F00, 1};
    vecs[5] = '{1, 16'hABCD,  0, 2'b01, 16'hABCD, 1};
    vecs[6] = '{0, 16'h8000, 16, 2'b10, 16'hFFFF, 2};
    vecs[7] = '{1, 16'h8000, 30, 2'b11, 16'h0000, 2};
    vecs[8] = '{0, 16'h8001, 31, 2'b00, 16'hC000, 3};
    vecs[9] = '{1, 16'h0001, 15, 2'b01, 16'h8000, 1};

    rst = 0; out_ready = 0;
    req0_valid = 0; req1_valid = 0;
    req0_in = 0; req1_in = 0; req0_cnt = 0; req1_cnt = 0; req0_op = 0; req1_op = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_busy", busy, 0);
    rst = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      do_req(vecs[i].id, vecs[i].din, vecs[i].cnt, vecs[i].op, vecs[i].exp_d, vecs[i].exp_p);

    // Two-pass rotate: check the intermediate pass value.
    req1_valid = 1; req1_in = 16'h1234; req1_cnt = 16; req1_op = 2'b00;
    #1;
    chk("mid_ready", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 0;
    @(posedge clk); #1;
    chk("mid_work", dut.work_data_q, 16'h091A);
    chk("mid_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("mid_out", out_data, 16'h1234);
    chk("mid_id", out_id, 1);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;

    // Backpressure with both requesters pending.
    req0_valid = 1; req0_in = 16'hF000; req0_cnt = 4; req0_op = 2'b11;
    #1;
    @(posedge clk); #1;
    req0_in = 16'h5555;
    req1_valid = 1; req1_in = 16'h1111; req1_cnt = 1; req1_op = 2'b01;
    @(posedge clk); #1;
    chk("bp_valid", out_valid, 1);
    hold_d = out_data; hold_id = out_id;
    chk("bp_data0", hold_d, 16'h0F00);
    for (int k = 0; k < 5; k++) begin
      chk("bp_data", out_data, 16'h0F00);
      chk("bp_id", out_id, 0);
      chk("bp_ready", {req0_ready, req1_ready}, 0);
      chk("bp_busy", busy, 1);
      @(posedge clk); #1;
    end
    out_ready = 1; req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    out_ready = 0;
    chk("bp_done_valid", out_valid, 0);
    chk("bp_done_busy", busy, 0);

    // Reset in the second RUN cycle of a three-pass request.
    req0_valid = 1; req0_in = 16'h8000; req0_cnt = 31; req0_op = 2'b10;
    #1;
    @(posedge clk); #1;
    req0_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_rr", dut.rr_ptr_q, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("mr_no_result", out_valid, 0);

    // Continuous contention: grants alternate starting from requester 0.
    req0_valid = 1; req0_in = 16'h0001; req0_cnt = 1; req0_op = 2'b01;
    req1_valid = 1; req1_in = 16'h0004; req1_cnt = 1; req1_op = 2'b11;
    out_ready = 1;
    ng = 0; no = 0; bad_ready = 0;
    #1;
    for (int cyc = 0; cyc < 60 && no < 4; cyc++) begin
      if (req0_ready && req1_ready) bad_ready++;
      if ((req0_ready || req1_ready) && busy) bad_ready++;
      if ((req0_ready || req1_ready) && ng < 8) begin
        grants[ng] = req1_ready ? 1 : 0;
        ng++;
      end
      if (out_valid && no < 8) begin
        ids[no] = out_id;
        chk("ct_data", out_data, out_id ? 16'h0002 : 16'h0002);
        no++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0; out_ready = 0;
    chk("ct_bad_ready", bad_ready, 0);
    chk("ct_nout", no, 4);
    chk("ct_ngrant", (ng >= 4) ? 1 : 0, 1);
    for (int k = 0; k < 4; k++) begin
      chk("ct_grant", grants[k], k % 2);
      chk("ct_out_id", ids[k], k % 2);
    end
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/shifter_sched.md
Name: shifter_sched

Overview:
- Shares one combinational `shifter` instance (N-bit data, C-bit count, 2-bit op) between two requesters.
- Arbitrates between them with round-robin priority and latches the winning request.
- Sequences multi-pass execution so that shift counts up to 2^(C+1)-1 are supported.
- Returns a registered result with a valid/ready handshake and a requester tag.
- Sits between the execute-stage issue logic and the shifter datapath.

Parameters:
- N, 16, data width
- C, 4, shifter count width; requester count width is C+1
- O, 2, op width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_in  in  N  requester 0 operand
- req0_cnt  in  C+1  requester 0 shift count
- req0_op  in  O  requester 0 op
- req1_valid, req1_ready, req1_in, req1_cnt, req1_op: same as requester 0, for requester 1
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_data  out  N  result
- out_id  out  1  index of the requester that produced the result
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: asynchronous, active-low. Reset values:
  - state = IDLE; rr_ptr = 0.
  - out_valid = 0; out_data = 0; out_id = 0; busy = 0.
  - Work registers = 0.
  - Reset mid-operation abandons the operation; no result is produced.
- Op encoding (owned by the shifter): 00 rotate left, 01 shift left logical, 10 shift right arithmetic, 11 shift right logical.
- States: IDLE, RUN, DONE.
- Arbitration (combinational, IDLE only):
  - grant = the requester whose valid is high.
  - If both are valid, grant = rr_ptr.
  - reqX_ready = (state == IDLE) && reqX_valid && (grant == X). Ready is never high in RUN or DONE.
- IDLE, on accept (reqX_valid && reqX_ready):
  - Latch work_data = reqX_in, rem = reqX_cnt, work_op = reqX_op, work_id = X.
  - rr_ptr <= ~X.
  - Go to RUN.
- RUN, each cycle:
  - The shifter is driven by In = work_data, Op = work_op, Cnt = min(rem, 2^C-1).
  - If rem > 2^C-1: work_data <= shifter Out, rem <= rem - (2^C-1), stay in RUN.
  - Otherwise: out_data <= shifter Out, out_id <= work_id, out_valid <= 1, go to DONE.
- DONE:
  - out_data and out_id are held stable while out_valid && !out_ready.
  - On out_ready: out_valid <= 0, go to IDLE. No accept in the same cycle.
- Latency, counted from the accepting edge to out_valid rising: P = max(1, ceil(cnt/(2^C-1))) cycles. For N=16:
  - cnt 0..15: P = 1
  - cnt 16..30: P = 2
  - cnt 31: P = 3
- Minimum issue interval: P + 2 cycles.
- Count 0: a single pass with Cnt = 0; the result equals the operand.
- Count >= N (non-rotate ops): the result follows from composing passes. sll/srl give 0; sra gives the sign fill.
- Simultaneous valids: exactly one is granted per accept, and they alternate under continuous contention.
- A requester may drop valid before it is accepted; the request is then simply not granted.
- Inputs are sampled only at the accepting edge; later changes do not affect the operation in flight.

Test Plan:
- Reset then single request: req0 = {0x8001, cnt 1, op 00} -> req0_ready=1 in cycle 0, out_valid=1 at edge 1, out_data=0x0003, out_id=0; with out_ready=1, back to IDLE next cycle.
- Two-pass rotate: req1 = {0x1234, cnt 16, op 00} -> intermediate work_data=0x091A, out_valid after 2 cycles, out_data=0x1234, out_id=1. Also req0 = {0x0001, cnt 20, op 01} -> out_data=0x0000 after 2 cycles.
- Three-pass arithmetic: req0 = {0x8000, cnt 31, op 10} -> out_data=0xFFFF after 3 cycles. Also {0xF000, cnt 4, op 11} -> 0x0F00 after 1 cycle.
- Contention: req0_valid and req1_valid held high, out_ready=1 -> grant order 0,1,0,1 with out_id matching; reqX_ready never high outside IDLE.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data/out_id stable, both req ready signals 0, busy=1; raising out_ready completes the handshake and returns to IDLE.
- Reset mid-RUN (cnt 31 request, rst low in the second RUN cycle) -> out_valid=0, busy=0, rr_ptr=0 immediately; the next request behaves as after a fresh reset.
